// File: rtl/seg7_reader.sv
// seg7_reader: debounces a 7-segment bus, decodes glyphs to BCD and checks the 0..9 count order.
// Define SEG7_READER_SEQ_CHECK_EN to enable out-of-order detection on seq_err.
module seg7_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] segments,
    input  logic       err_clr,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       wrap,
    output logic       locked,
    output logic       pattern_err,
    output logic       seq_err,
    output logic [7:0] tick_count
);
    typedef enum logic {UNLOCKED, LOCKED} state_t;
    localparam logic [3:0] STAB_MAX = 4'(STABLE_CYCLES);
    state_t state;
    logic [6:0] last_sample, acc_pattern;
    logic [3:0] stab_cnt, dec_digit;
    logic same, accept, blank, dec_valid;
    assign same   = segments == last_sample;
    assign accept = same && stab_cnt == STAB_MAX - 4'd1 && last_sample != acc_pattern;
    assign blank  = last_sample == 7'd0;
    assign locked = state == LOCKED;
    always_comb begin
        dec_valid = 1'b1;
        dec_digit = 4'd0;
        case (last_sample)
            7'b0111111: dec_digit = 4'd0;
            7'b0000110: dec_digit = 4'd1;
            7'b1011011: dec_digit = 4'd2;
            7'b1001111: dec_digit = 4'd3;
            7'b1100110: dec_digit = 4'd4;
            7'b1101101: dec_digit = 4'd5;
            7'b1111100: dec_digit = 4'd6;
            7'b0000111: dec_digit = 4'd7;
            7'b1111111: dec_digit = 4'd8;
            7'b1100111: dec_digit = 4'd9;
            default:    dec_valid = 1'b0;
        endcase
    end
`ifdef SEG7_READER_SEQ_CHECK_EN
    logic [3:0] next_digit;
    assign next_digit = digit == 4'd9 ? 4'd0 : digit + 4'd1;
`else
    assign seq_err = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= UNLOCKED;
            last_sample <= 7'd0;
            acc_pattern <= 7'd0;
            stab_cnt    <= 4'd0;
            digit       <= 4'd0;
            digit_valid <= 1'b0;
            wrap        <= 1'b0;
            pattern_err <= 1'b0;
            tick_count  <= 8'd0;
`ifdef SEG7_READER_SEQ_CHECK_EN
            seq_err     <= 1'b0;
`endif
        end else begin
            digit_valid <= 1'b0;
            wrap        <= 1'b0;
            if (err_clr) begin
                pattern_err <= 1'b0;
`ifdef SEG7_READER_SEQ_CHECK_EN
                seq_err     <= 1'b0;
`endif
            end
            if (same) begin
                stab_cnt <= stab_cnt == STAB_MAX ? stab_cnt : stab_cnt + 4'd1;
            end else begin
                last_sample <= segments;
                stab_cnt    <= 4'd1;
            end
            // later assignments give error sets priority over err_clr
            if (accept) begin
                acc_pattern <= last_sample;
                if (!dec_valid && !blank) begin
                    pattern_err <= 1'b1;
                    state       <= UNLOCKED;
                end else if (dec_valid) begin
                    digit       <= dec_digit;
                    digit_valid <= 1'b1;
                    tick_count  <= tick_count + 8'd1;
                    state       <= LOCKED;
                    if (state == LOCKED && digit == 4'd9 && dec_digit == 4'd0)
                        wrap <= 1'b1;
`ifdef SEG7_READER_SEQ_CHECK_EN
                    if (state == LOCKED && dec_digit != next_digit)
                        seq_err <= 1'b1;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_seg7_reader.sv
// tb_seg7_reader: table vectors, corner sequences and random traffic against a run-length reference model.
module tb_seg7_reader;
    localparam int S = 4;
`ifdef SEG7_READER_SEQ_CHECK_EN
    localparam bit SEQ = 1'b1;
`else
    localparam bit SEQ = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b1, err_clr = 1'b0;
    logic [6:0] segments = 7'd0;
    logic [3:0] digit;
    logic digit_valid, wrap, locked, pattern_err, seq_err;
    logic [7:0] tick_count;
    int n_cmp = 0, n_err = 0, n_dv = 0, n_wrap = 0;
    logic [6:0] glyph [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                               7'b1101101, 7'b1111100, 7'b0000111, 7'b1111111, 7'b1100111};
    logic [6:0] run_val, acc;
    int run_len, m_digit, m_tick;
    bit m_locked, m_dv, m_wrap, m_perr, m_serr;

    seg7_reader #(.STABLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .segments(segments), .err_clr(err_clr),
        .digit(digit), .digit_valid(digit_valid), .wrap(wrap), .locked(locked),
        .pattern_err(pattern_err), .seq_err(seq_err), .tick_count(tick_count)
    );

    always #5 clk = ~clk;

    function automatic int decode(input logic [6:0] p);
        if (p == 7'd0) return -2;
        for (int i = 0; i < 10; i++) if (glyph[i] == p) return i;
        return -1;
    endfunction

    task automatic model_edge(input logic [6:0] s, input bit c, input bit r);
        int d;
        if (r) begin
            run_val = 7'd0; run_len = 0; acc = 7'd0;
            m_digit = 0; m_tick = 0; m_locked = 0; m_dv = 0; m_wrap = 0; m_perr = 0; m_serr = 0;
            return;
        end
        m_dv = 0; m_wrap = 0;
        if (c) begin m_perr = 0; m_serr = 0; end
        if (s == run_val) run_len++;
        else begin run_val = s; run_len = 1; end
        if (run_len == S && run_val != acc) begin
            acc = run_val;
            d = decode(run_val);
            if (d == -1) begin
                m_perr = 1; m_locked = 0;
            end else if (d >= 0) begin
                if (m_locked) begin
                    if (d != (m_digit + 1) % 10) m_serr = SEQ;
                    if (m_digit == 9 && d == 0) m_wrap = 1;
                end
                m_digit = d; m_dv = 1; m_tick = (m_tick + 1) % 256; m_locked = 1;
            end
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [6:0] s, input bit c, input bit r);
        segments = s; err_clr = c; reset = r;
        @(posedge clk);
        model_edge(s, c, r);
        @(negedge clk);
        n_dv += int'(digit_valid === 1'b1);
        n_wrap += int'(wrap === 1'b1);
        check("digit", 8'(digit), 8'(m_digit));
        check("digit_valid", 8'(digit_valid), 8'(m_dv));
        check("wrap", 8'(wrap), 8'(m_wrap));
        check("locked", 8'(locked), 8'(m_locked));
        check("pattern_err", 8'(pattern_err), 8'(m_perr));
        check("seq_err", 8'(seq_err), 8'(m_serr));
        check("tick_count", tick_count, 8'(m_tick));
    endtask

    typedef struct {
        logic [6:0] seg;
        bit clr;
        int hold;
        int dig;
        bit lck;
        bit perr;
        bit serr;
        int tick;
    } vec_t;
    vec_t vt[$];

    initial begin
        int guard, k;
        logic [6:0] p;
        for (int i = 0; i < 10; i++) vt.push_back('{glyph[i], 0, 10, i, 1, 0, 0, i + 1});
        vt.push_back('{glyph[0], 0, 10, 0, 1, 0, 0, 11});
        vt.push_back('{glyph[1], 0, 10, 1, 1, 0, 0, 12});
        vt.push_back('{glyph[2], 0, 10, 2, 1, 0, 0, 13});
        vt.push_back('{glyph[3], 0, 10, 3, 1, 0, 0, 14});
        vt.push_back('{7'd0,     0, 2,  3, 1, 0, 0, 14});
        vt.push_back('{glyph[3], 0, 10, 3, 1, 0, 0, 14});
        vt.push_back('{glyph[4], 0, 10, 4, 1, 0, 0, 15});
        vt.push_back('{glyph[7], 0, 10, 7, 1, 0, SEQ, 16});
        vt.push_back('{glyph[7], 1, 1,  7, 1, 0, 0, 16});
        vt.push_back('{glyph[7], 0, 3,  7, 1, 0, 0, 16});
        vt.push_back('{7'b1010101, 0, 10, 7, 0, 1, 0, 16});
        vt.push_back('{glyph[5], 0, 10, 5, 1, 1, 0, 17});

        // reset state and first-acceptance latency
        step(7'd0, 0, 1);
        check("reset_outputs", {digit_valid, wrap, locked, pattern_err, seq_err, 3'd0}, 8'd0);
        for (int i = 1; i <= S + 1; i++) begin
            step(glyph[0], 0, 0);
            check("latency_pulse", 8'(digit_valid), 8'(i == S));
        end
        check("latency_lock", {locked, 3'd0, digit}, 8'h80);
        check("latency_tick", tick_count, 8'd1);

        // table-driven scenario
        step(7'd0, 0, 1);
        step(7'd0, 0, 1);
        n_dv = 0; n_wrap = 0;
        foreach (vt[i]) begin
            for (int h = 0; h < vt[i].hold; h++) step(vt[i].seg, vt[i].clr, 0);
            check("vec_digit", 8'(digit), 8'(vt[i].dig));
            check("vec_locked", 8'(locked), 8'(vt[i].lck));
            check("vec_pattern_err", 8'(pattern_err), 8'(vt[i].perr));
            check("vec_seq_err", 8'(seq_err), 8'(vt[i].serr));
            check("vec_tick", tick_count, 8'(vt[i].tick));
        end
        check("vec_pulses", 8'(n_dv), 8'd17);
        check("vec_wraps", 8'(n_wrap), 8'd1);

        // reset mid-debounce with tick_count at 200
        step(7'd0, 0, 1);
        guard = 0; k = 0;
        while (m_tick != 200 && guard < 4000) begin
            for (int h = 0; h < S; h++) step(glyph[k % 10], 0, 0);
            k++; guard += S;
        end
        check("tick200", tick_count, 8'd200);
        step(glyph[k % 10], 0, 0);
        step(glyph[k % 10], 0, 0);
        step(glyph[k % 10], 0, 1);
        check("rst_mid_outputs", {digit_valid, wrap, locked, pattern_err, seq_err, 3'd0}, 8'd0);
        check("rst_mid_tick", tick_count, 8'd0);
        check("rst_mid_digit", 8'(digit), 8'd0);
        for (int i = 1; i <= S; i++) begin
            step(glyph[k % 10], 0, 0);
            check("rst_fresh_pulse", 8'(digit_valid), 8'(i == S));
        end
        check("rst_fresh_tick", tick_count, 8'd1);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            int r = $urandom_range(0, 99);
            p = r < 60 ? glyph[(m_digit + 1) % 10] : r < 75 ? glyph[$urandom_range(0, 9)] :
                r < 85 ? 7'd0 : 7'($urandom);
            for (int h = $urandom_range(1, 7); h > 0; h--)
                step(p, $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seg7_reader.md
# seg7_reader

Receive-side counterpart of the seven-segment seconds counter: samples a 7-bit segment bus, debounces it, decodes the glyph back to a BCD digit, and checks that successive digits follow the 0→9→0 count. It sits on a board-level or loopback monitor path and reports lock, errors and an accepted-digit count, so the counter can be verified in silicon.

## Interface
Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required to accept a pattern; legal range 2..15.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- segments  input  7  segment bus, bit0=a … bit6=g, 1 = lit.
- err_clr  input  1  clears sticky error flags.
- digit  output  4  last accepted decoded digit 0..9.
- digit_valid  output  1  one-cycle pulse when `digit` updates.
- wrap  output  1  one-cycle pulse when a 9→0 transition is accepted while locked.
- locked  output  1  high once a valid digit is accepted; low after an invalid glyph.
- pattern_err  output  1  sticky; an invalid non-blank glyph was accepted.
- seq_err  output  1  sticky; an out-of-order digit was accepted while locked.
- tick_count  output  8  count of accepted valid digits; wraps 255→0.

## Operation
- Glyph table (g..a): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111100, 7=0000111, 8=1111111, 9=1100111. Blank=0000000. Every other code is invalid.
- Debounce: registers `last_sample` (7b) and `stab_cnt` (4b).
  - Each edge, if `segments == last_sample`, `stab_cnt` increments, saturating at STABLE_CYCLES.
  - Otherwise `last_sample <= segments` and `stab_cnt <= 1`.
- Acceptance: on the edge where `stab_cnt` reaches STABLE_CYCLES, and only if `last_sample != acc_pattern`, the pattern is accepted and `acc_pattern <= last_sample`. A pattern is accepted at most once per appearance.
- State machine `UNLOCKED`/`LOCKED`; reset enters `UNLOCKED`.
  - Accepted blank: no output change, state unchanged.
  - Accepted invalid glyph: `pattern_err` set, go to `UNLOCKED`. `digit` is held.
  - Valid digit d in `UNLOCKED`: `digit <= d`, pulse `digit_valid`, increment `tick_count`, go to `LOCKED`. No sequence check.
  - Valid digit d in `LOCKED`: `digit <= d`, pulse `digit_valid`, increment `tick_count`.
    - If d != (digit+1) mod 10, set `seq_err` (see Configuration).
    - If digit==9 and d==0, pulse `wrap`.
    - Stay in `LOCKED`.
- `locked` is high exactly in state `LOCKED`.
- `err_clr` clears `pattern_err` and `seq_err`. If a set and `err_clr` occur on the same edge, the set wins.
- Sequence arithmetic is 4-bit with explicit 9→0 wrap; `tick_count` is 8-bit modulo 256.

## Timing
- Reset values: `digit`=0, `digit_valid`=0, `wrap`=0, `locked`=0, `pattern_err`=0, `seq_err`=0, `tick_count`=0.
- Internal reset values: `last_sample`=0000000, `stab_cnt`=0, `acc_pattern`=0000000. A blank bus is therefore never accepted immediately after reset.
- Latency: a new pattern first present at edge E0 and held is accepted at edge E0+STABLE_CYCLES-1. All outputs change registered on that edge, so `digit_valid` is visible for the cycle following it.
- A glitch shorter than STABLE_CYCLES edges is never accepted and does not disturb `acc_pattern`.
- A return to the previously accepted pattern after a glitch produces no pulse.
- Reset asserted mid-debounce or mid-lock discards all progress; the first pattern accepted afterwards is treated as from `UNLOCKED`.
- `digit_valid` and `wrap` are high for exactly one cycle. Back-to-back acceptances are at least STABLE_CYCLES cycles apart.

## Configuration
- SEG7_READER_SEQ_CHECK_EN defined: the sequence check operates as above and `seq_err` behaves as specified.
- Undefined: no sequence comparison logic; `seq_err` is tied to 0. `wrap` still pulses on an accepted 9→0 transition while locked; all other behaviour is unchanged.

## Test plan
- Reset, then hold the 0 glyph for 4 cycles → `digit_valid` pulses once with `digit`=0, `locked`=1, `tick_count`=1.
- Drive 0..9 then 0, each held 10 cycles → 11 pulses, one `wrap` pulse on the final 0, `seq_err`=0, `tick_count`=11.
- While locked on 3, glitch to 0000000 for 2 cycles and back to 3 → no pulse, no state change.
- Locked on 4, then hold 7 → `digit`=7, `seq_err`=1 (macro defined) or 0 (undefined); then `err_clr` → `seq_err`=0.
- Hold invalid code 1010101 for 4 cycles → `pattern_err`=1, `locked`=0, `digit` held; then 5 → `locked`=1, no `seq_err`.
- Assert reset while `stab_cnt`=2 and `tick_count`=200 → all outputs 0 on the next cycle; the same glyph needs 4 fresh cycles to be accepted.
